// File: rtl/cache_tag_array_nway.sv
// N-way set-associative tag store: per-set valid/dirty/tag, tree pseudo-LRU,
// registered hit/victim lookup and a one-set-per-cycle invalidate sweep.

module cache_tag_way_cmp #(
  parameter int TAG_W = 25
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] stored,
  input  logic [TAG_W-1:0] tag,
  output logic             match
);
  assign match = vld && (stored == tag);
endmodule

module cache_tag_array_nway #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int IDX_W    = 5,
  parameter int WAYS     = 2,
  localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              resp_valid,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [WAY_W-1:0]  victim_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WAY_W-1:0]  wr_way,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic              inval_all,
  output logic              busy
);
  localparam int IDX_SIZE = 1 << IDX_W;
  localparam int LVLS     = $clog2(WAYS);
  localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {INIT, IDLE, INVAL} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;

  logic [WAYS-1:0]             vld_mem   [IDX_SIZE];
  logic [WAYS-1:0]             dirty_mem [IDX_SIZE];
  logic [WAYS-1:0][TAG_W-1:0]  tag_mem   [IDX_SIZE];
  logic [PLRU_W-1:0]           plru_mem  [IDX_SIZE];

  // Heap-ordered tree: node n (1-based) lives at bit n-1, bit=1 steers to the upper half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] p);
    int   node;
    logic b;
    node = 1;
    for (int l = 0; l < LVLS; l++) begin
      b = 1'b0;
      for (int n = 1; n < WAYS; n++) if (n == node) b = p[n-1];
      node = 2 * node + int'(b);
    end
    return WAY_W'(node - WAYS);
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] p,
                                                   input logic [WAY_W-1:0]  w);
    int               node;
    logic             d;
    logic [PLRU_W-1:0] q;
    node = 1;
    q    = p;
    for (int l = 0; l < LVLS; l++) begin
      d = w[LVLS-1-l];
      for (int n = 1; n < WAYS; n++) if (n == node) q[n-1] = ~d;
      node = 2 * node + int'(d);
    end
    return q;
  endfunction

  logic [IDX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  logic             lk_acc, wr_acc;
  logic             unused_addr_bits;

  assign lk_idx = lookup_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign lk_tag = lookup_addr[ADDR_W-1:IDX_W+OFFSET_W];
  assign wr_idx = wr_addr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign wr_tag = wr_addr[ADDR_W-1:IDX_W+OFFSET_W];
  assign lk_acc = lookup_valid & ~busy;
  assign wr_acc = wr_en & ~busy;
  assign unused_addr_bits = ^{lookup_addr[OFFSET_W-1:0], wr_addr[OFFSET_W-1:0]};

  logic [WAYS-1:0]            rd_vld, rd_dirty, match;
  logic [WAYS-1:0][TAG_W-1:0] rd_tag;
  logic [PLRU_W-1:0]          rd_plru;

  assign rd_vld   = vld_mem[lk_idx];
  assign rd_dirty = dirty_mem[lk_idx];
  assign rd_tag   = tag_mem[lk_idx];
  assign rd_plru  = plru_mem[lk_idx];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_tag_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .vld(rd_vld[w]), .stored(rd_tag[w]), .tag(lk_tag), .match(match[w])
    );
  end

  logic             lk_hit, has_inv;
  logic [WAY_W-1:0] lk_hit_way, inv_way, lk_vic;

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    has_inv    = 1'b0;
    inv_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])   begin lk_hit  = 1'b1; lk_hit_way = WAY_W'(w); end
      if (!rd_vld[w]) begin has_inv = 1'b1; inv_way    = WAY_W'(w); end
    end
    lk_vic = has_inv ? inv_way : plru_victim(rd_plru);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        INIT, INVAL: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: if (inval_all) begin
          state <= INVAL;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      resp_valid   <= 1'b0;
      hit          <= 1'b0;
      hit_way      <= '0;
      victim_way   <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      resp_valid <= lk_acc;
      if (lk_acc) begin
        hit          <= lk_hit;
        hit_way      <= lk_hit_way;
        victim_way   <= lk_vic;
        victim_valid <= rd_vld[lk_vic];
        victim_dirty <= rd_dirty[lk_vic];
        victim_tag   <= rd_tag[lk_vic];
      end
    end
  end

  // Write's PLRU update is placed last so it overrides a same-set hit update.
  always_ff @(posedge iCLK) begin
    if (busy) begin
      vld_mem[cnt]   <= '0;
      dirty_mem[cnt] <= '0;
      plru_mem[cnt]  <= '0;
    end else begin
      if (lk_acc && lk_hit) plru_mem[lk_idx] <= plru_touch(rd_plru, lk_hit_way);
      if (wr_acc) begin
        if (wr_valid) plru_mem[wr_idx] <= plru_touch(plru_mem[wr_idx], wr_way);
        vld_mem[wr_idx][wr_way]   <= wr_valid;
        dirty_mem[wr_idx][wr_way] <= wr_dirty;
        tag_mem[wr_idx][wr_way]   <= wr_tag;
      end
    end
  end
endmodule
